uart_cmd_ctrl: RTL

Command-frame controller between `uart_rx` and the logic-analyzer core.
- Consumes the received byte stream (`o_Rx_DV` / `o_Rx_Byte`) and assembles fixed-length 7-byte frames.
- Checks each frame's checksum and legality.
- Issues one-cycle configuration-write, arm and abort strobes to the capture engine.
- Recovers from line noise and truncated frames with an inter-byte timeout.

---
 rtl/la_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_ctrl_if.sv | 33 +++
 rtl/cmd_timeout_timer.sv | 27 ++
 rtl/uart_cmd_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/la_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package la_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPCODE = 2'd1,
    S_DATA   = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_CHECKSUM = 2'd0,
    ERR_OPCODE   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BUSY     = 2'd3
  } err_code_t;

  localparam logic [3:0] OP_WRITE_HI       = 4'h1;
  localparam logic [7:0] OP_ARM            = 8'h20;
  localparam logic [7:0] OP_ABORT          = 8'h21;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input and capture-engine command outputs of uart_cmd_ctrl.
interface uart_cmd_ctrl_if;
  import la_cmd_pkg::*;

  // Handshake: i_rx_dv is a one-cycle valid with no ready; the controller
  // always accepts the byte present while i_rx_dv is high. Every o_* strobe
  // is a one-cycle registered pulse with no back-pressure.
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        i_busy;
  logic        o_cfg_wr_en;
  logic [3:0]  o_cfg_addr;
  logic [31:0] o_cfg_wdata;
  logic        o_arm;
  logic        o_abort;
  logic        o_frame_err;
  logic [1:0]  o_err_code;
  logic        o_frame_active;
  state_t      dbg_state;

  modport slave (
    input  i_rx_dv, i_rx_byte, i_busy,
    output o_cfg_wr_en, o_cfg_addr, o_cfg_wdata, o_arm, o_abort,
           o_frame_err, o_err_code, o_frame_active, dbg_state
  );

  modport master (
    output i_rx_dv, i_rx_byte, i_busy,
    input  o_cfg_wr_en, o_cfg_addr, o_cfg_wdata, o_arm, o_abort,
           o_frame_err, o_err_code, o_frame_active, dbg_state
  );

endinterface

// File: rtl/cmd_timeout_timer.sv
// Inter-byte idle counter; terminal stays high at TIMEOUT_CLKS-1 until cleared.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CLKS = 208_320
) (
  input  logic i_Clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(TIMEOUT_CLKS);
  localparam logic [W-1:0] TC = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_Clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable && count != TC) begin
      count <= count + W'(1);
    end
  end

  assign terminal = (count == TC);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 7-byte command frames from uart_rx and issues config/arm/abort strobes.
module uart_cmd_ctrl
  import la_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         NUM_REGS     = 8,
  parameter int         TIMEOUT_CLKS = 208_320
) (
  input  logic             i_Clock,
  input  logic             reset_n,
  uart_cmd_ctrl_if.slave   bus
);

  state_t      state, state_next;
  logic [7:0]  op_q;
  logic [7:0]  acc_q;
  logic [31:0] wdata_q;
  logic [1:0]  byte_cnt_q;
  logic        timeout_tc;
  logic        op_is_write;
  logic        op_legal;
  logic        do_wr, do_arm, do_abort, do_err;
  err_code_t   err_next;

  cmd_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .i_Clock  (i_Clock),
    .reset_n  (reset_n),
    .clear    (bus.i_rx_dv || state == S_IDLE),
    .enable   (state != S_IDLE),
    .terminal (timeout_tc)
  );

  assign op_is_write = (op_q[7:4] == OP_WRITE_HI);
  assign op_legal    = (op_is_write && ({28'd0, op_q[3:0]} < NUM_REGS)) ||
                       op_q == OP_ARM || op_q == OP_ABORT;

  always_ff @(posedge i_Clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_wr      = 1'b0;
    do_arm     = 1'b0;
    do_abort   = 1'b0;
    do_err     = 1'b0;
    err_next   = ERR_CHECKSUM;
    case (state)
      S_IDLE:   if (bus.i_rx_dv && bus.i_rx_byte == SYNC_BYTE) state_next = S_OPCODE;
      S_OPCODE: if (bus.i_rx_dv) state_next = S_DATA;
      S_DATA:   if (bus.i_rx_dv && byte_cnt_q == 2'd3) state_next = S_CHECK;
      S_CHECK: begin
        if (bus.i_rx_dv) begin
          state_next = S_IDLE;
          if (bus.i_rx_byte != acc_q) begin
            do_err   = 1'b1;
            err_next = ERR_CHECKSUM;
          end else if (!op_legal) begin
            do_err   = 1'b1;
            err_next = ERR_OPCODE;
          end else if (bus.i_busy && op_q != OP_ABORT) begin
            do_err   = 1'b1;
            err_next = ERR_BUSY;
          end else if (op_is_write) begin
            do_wr = 1'b1;
          end else if (op_q == OP_ARM) begin
            do_arm = 1'b1;
          end else begin
            do_abort = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A byte arriving on the terminal count cycle takes precedence.
    if (state != S_IDLE && !bus.i_rx_dv && timeout_tc) begin
      state_next = S_IDLE;
      do_wr      = 1'b0;
      do_arm     = 1'b0;
      do_abort   = 1'b0;
      do_err     = 1'b1;
      err_next   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!reset_n) begin
      op_q            <= '0;
      acc_q           <= '0;
      wdata_q         <= '0;
      byte_cnt_q      <= '0;
      bus.o_cfg_wr_en <= 1'b0;
      bus.o_cfg_addr  <= '0;
      bus.o_cfg_wdata <= '0;
      bus.o_arm       <= 1'b0;
      bus.o_abort     <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_err_code  <= '0;
    end else begin
      bus.o_cfg_wr_en <= do_wr;
      bus.o_arm       <= do_arm;
      bus.o_abort     <= do_abort;
      bus.o_frame_err <= do_err;
      if (do_wr) begin
        bus.o_cfg_addr  <= op_q[3:0];
        bus.o_cfg_wdata <= wdata_q;
      end
      if (do_err) bus.o_err_code <= err_next;
      if (bus.i_rx_dv) begin
        case (state)
          S_OPCODE: begin
            op_q       <= bus.i_rx_byte;
            acc_q      <= bus.i_rx_byte;
            byte_cnt_q <= 2'd0;
          end
          S_DATA: begin
            // Shifting in from the top leaves {D3,D2,D1,D0} after four bytes.
            wdata_q    <= {bus.i_rx_byte, wdata_q[31:8]};
            acc_q      <= acc_q ^ bus.i_rx_byte;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_frame_active = (state != S_IDLE);
  assign bus.dbg_state      = state;

endmodule
